crc24_attach: RTL

Parametrised, stream-based CRC attachment engine for the code-block segmentation datapath. It accepts a payload stream of DATA_W-bit beats under a valid/ready handshake and forwards it through one register stage. It computes CRC24A or CRC24B, selected per frame, over the payload and appends the CRC_W-bit result as CRC_W/DATA_W extra beats, MSB first. It sits between the transport-block source and the segmentation/filler logic, and also serves as the per-code-block CRC stage.

---
 rtl/crc24_attach.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/crc24_attach.sv
// rtl/crc24_attach.sv - stream CRC24A/CRC24B attach engine with one output register stage
// Payload beats pass through; the CRC follows as CRC_W/DATA_W beats, MSB slice first.
module crc24_attach #(
  parameter int               DATA_W = 8,
  parameter int               CRC_W  = 24,
  parameter logic [CRC_W-1:0] POLY_A = 24'h864CFB,
  parameter logic [CRC_W-1:0] POLY_B = 24'h800063,
  parameter logic [CRC_W-1:0] INIT   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              crc_sel,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              busy
);

  localparam int NBEATS = CRC_W / DATA_W;
  localparam int CNT_W  = $clog2(NBEATS + 1);

  typedef enum logic [1:0] {IDLE, DATA, APPEND} state_t;

  state_t              state_q, state_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic                sel_q, sel_d;
  logic [CRC_W-1:0]    shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CRC_W-1:0]    crc_out_q, crc_out_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;

  logic                out_free;
  logic                in_fire;
  logic                sel_eff;
  logic [CRC_W-1:0]    poly_eff;
  logic [CRC_W-1:0]    crc_base;
  logic [CRC_W-1:0]    crc_next;

  // Bit-serial definition, unrolled by the loop into one XOR network per beat.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc_in,
                                                input logic [DATA_W-1:0] data,
                                                input logic [CRC_W-1:0] poly);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ data[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
    end
    return c;
  endfunction

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q != APPEND) && out_free;
  assign in_fire  = in_valid && in_ready;

  // The first beat of a frame uses the live crc_sel and INIT; later beats use the latched values.
  assign sel_eff  = (state_q == IDLE) ? crc_sel : sel_q;
  assign poly_eff = sel_eff ? POLY_B : POLY_A;
  assign crc_base = (state_q == IDLE) ? INIT : crc_q;
  assign crc_next = crc_step(crc_base, in_data, poly_eff);

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    sel_d       = sel_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    crc_out_d   = crc_out_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (out_free) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      IDLE, DATA: begin
        if (in_fire) begin
          crc_d       = crc_next;
          out_data_d  = in_data;
          out_valid_d = 1'b1;
          if (state_q == IDLE) begin
            sel_d = crc_sel;
          end
          if (in_last) begin
            state_d   = APPEND;
            shift_d   = crc_next;
            cnt_d     = '0;
            crc_out_d = crc_next;
          end else begin
            state_d = DATA;
          end
        end
      end
      APPEND: begin
        // Once the last CRC beat is loaded, wait for it to drain before accepting a new frame.
        if (out_valid_q && out_last_q && out_ready) begin
          state_d = IDLE;
        end else if (out_free && (cnt_q != CNT_W'(NBEATS))) begin
          out_data_d  = shift_q[CRC_W-1 -: DATA_W];
          out_valid_d = 1'b1;
          out_last_d  = (cnt_q == CNT_W'(NBEATS - 1));
          shift_d     = shift_q << DATA_W;
          cnt_d       = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      crc_q       <= '0;
      sel_q       <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      crc_out_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      sel_q       <= sel_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      crc_out_q   <= crc_out_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign crc_out   = crc_out_q;
  assign busy      = (state_q != IDLE);

endmodule
